// File: rtl/sm_para_pkg.sv
// Shared encodings and helpers for the sm_para stimulus driver: target FSM
// states and output codes, request codes, driver states and the FSM model.
package sm_para_pkg;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_S1   = 3'b001;
  localparam logic [2:0] ST_S2   = 3'b010;
  localparam logic [2:0] ST_ERR  = 3'b100;

  localparam logic [2:0] CODE_IDLE = 3'b000;
  localparam logic [2:0] CODE_S1   = 3'b100;
  localparam logic [2:0] CODE_S2   = 3'b010;
  localparam logic [2:0] CODE_ERR  = 3'b111;

  localparam logic [1:0] REQ_IDLE = 2'd0;
  localparam logic [1:0] REQ_S1   = 2'd1;
  localparam logic [1:0] REQ_S2   = 2'd2;
  localparam logic [1:0] REQ_ERR  = 2'd3;

  typedef enum logic [1:0] {D_IDLE, D_STEP, D_CHECK, D_RESP} drv_state_e;

  function automatic logic [2:0] req_to_state(input logic [1:0] req);
    case (req)
      REQ_S1:  return ST_S1;
      REQ_S2:  return ST_S2;
      REQ_ERR: return ST_ERR;
      default: return ST_IDLE;
    endcase
  endfunction

  // {i1,i2} that leaves the target FSM where it is
  function automatic logic [1:0] hold_vec(input logic [2:0] st);
    case (st)
      ST_S2:   return 2'b01;
      ST_ERR:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] state_code(input logic [2:0] st);
    case (st)
      ST_S1:   return CODE_S1;
      ST_S2:   return CODE_S2;
      ST_ERR:  return CODE_ERR;
      default: return CODE_IDLE;
    endcase
  endfunction

  // Any code outside the four legal ones is treated as IDLE
  function automatic logic [2:0] code_to_state(input logic [2:0] code);
    case (code)
      CODE_S1:  return ST_S1;
      CODE_S2:  return ST_S2;
      CODE_ERR: return ST_ERR;
      default:  return ST_IDLE;
    endcase
  endfunction

  function automatic logic [2:0] fsm_next(input logic [2:0] st, input logic [1:0] v);
    logic in1, in2;
    in1 = v[1];
    in2 = v[0];
    case (st)
      ST_IDLE: return !in1 ? ST_IDLE : (in2 ? ST_S1 : ST_ERR);
      ST_S1:   return !in2 ? ST_S1 : (in1 ? ST_S2 : ST_ERR);
      ST_S2:   return in2 ? ST_S2 : (in1 ? ST_IDLE : ST_ERR);
      ST_ERR:  return in1 ? ST_ERR : ST_IDLE;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sm_para_path_rom.sv
// Shortest {i1,i2} path between two target FSM states: step count plus up to
// three vectors, applied in order vec0, vec1, vec2.
module sm_para_path_rom
  import sm_para_pkg::*;
(
  input  logic [2:0] from_i,
  input  logic [2:0] to_i,
  output logic [1:0] steps_o,
  output logic [1:0] vec0_o,
  output logic [1:0] vec1_o,
  output logic [1:0] vec2_o
);

  always_comb begin
    steps_o = 2'd0;
    vec0_o  = 2'b00;
    vec1_o  = 2'b00;
    vec2_o  = 2'b00;
    case (to_i)
      ST_IDLE: begin
        case (from_i)
          ST_S1:   begin steps_o = 2'd2; vec0_o = 2'b11; vec1_o = 2'b10; end
          ST_S2:   begin steps_o = 2'd1; vec0_o = 2'b10; end
          ST_ERR:  begin steps_o = 2'd1; vec0_o = 2'b00; end
          default: steps_o = 2'd0;
        endcase
      end
      ST_S1: begin
        case (from_i)
          ST_IDLE: begin steps_o = 2'd1; vec0_o = 2'b11; end
          ST_S2:   begin steps_o = 2'd2; vec0_o = 2'b10; vec1_o = 2'b11; end
          ST_ERR:  begin steps_o = 2'd2; vec0_o = 2'b00; vec1_o = 2'b11; end
          default: steps_o = 2'd0;
        endcase
      end
      ST_S2: begin
        case (from_i)
          ST_IDLE: begin steps_o = 2'd2; vec0_o = 2'b11; vec1_o = 2'b11; end
          ST_S1:   begin steps_o = 2'd1; vec0_o = 2'b11; end
          ST_ERR:  begin steps_o = 2'd3; vec0_o = 2'b00; vec1_o = 2'b11; vec2_o = 2'b11; end
          default: steps_o = 2'd0;
        endcase
      end
      ST_ERR: begin
        case (from_i)
          ST_IDLE: begin steps_o = 2'd1; vec0_o = 2'b10; end
          ST_S1:   begin steps_o = 2'd1; vec0_o = 2'b01; end
          ST_S2:   begin steps_o = 2'd1; vec0_o = 2'b00; end
          default: steps_o = 2'd0;
        endcase
      end
      default: steps_o = 2'd0;
    endcase
  end

endmodule

// File: rtl/sm_para_2_driver.sv
// Request-driven stimulus initiator: walks the target FSM to a requested state
// one step at a time, checking its outputs after every step.
module sm_para_2_driver
  import sm_para_pkg::*;
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_state,
  output logic             i1,
  output logic             i2,
  input  logic             o1,
  input  logic             o2,
  input  logic             err,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [1:0]       resp_steps,
  output logic [CNT_W-1:0] mis_cnt
);

  drv_state_e       drv_q;
  logic [2:0]       pst_q, src_q, tgt_q;
  logic [1:0]       idx_q, drive_q, resp_steps_q;
  logic             resp_valid_q, resp_err_q;
  logic [CNT_W-1:0] mis_q;

  logic [2:0] req_tgt, rom_from, rom_to, obs_code, obs_st_d, pst_step_d;
  logic [1:0] rom_steps, rom_v0, rom_v1, rom_v2, step_vec_d;
  logic       accept, check_ok;

  // The ROM looks at the live request while idle, then at the latched pair
  sm_para_path_rom u_rom (
    .from_i  (rom_from),
    .to_i    (rom_to),
    .steps_o (rom_steps),
    .vec0_o  (rom_v0),
    .vec1_o  (rom_v1),
    .vec2_o  (rom_v2)
  );

  always_comb begin
    req_tgt    = req_to_state(req_state);
    rom_from   = (drv_q == D_IDLE) ? pst_q : src_q;
    rom_to     = (drv_q == D_IDLE) ? req_tgt : tgt_q;
    accept     = req_valid && (drv_q == D_IDLE);
    obs_code   = {o1, o2, err};
    obs_st_d   = code_to_state(obs_code);
    check_ok   = (obs_code == state_code(pst_q));
    pst_step_d = fsm_next(pst_q, drive_q);
    case (idx_q)
      2'd0:    step_vec_d = rom_v0;
      2'd1:    step_vec_d = rom_v1;
      default: step_vec_d = rom_v2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drv_q        <= D_IDLE;
      pst_q        <= ST_IDLE;
      src_q        <= ST_IDLE;
      tgt_q        <= ST_IDLE;
      idx_q        <= 2'd0;
      drive_q      <= 2'b00;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_steps_q <= 2'd0;
      mis_q        <= '0;
    end else begin
      case (drv_q)
        D_IDLE: begin
          drive_q <= hold_vec(pst_q);
          if (accept) begin
            src_q      <= pst_q;
            tgt_q      <= req_tgt;
            idx_q      <= 2'd0;
            resp_err_q <= 1'b0;
            if (rom_steps != 2'd0) begin
              drv_q   <= D_STEP;
              drive_q <= rom_v0;
            end else begin
              drv_q <= D_CHECK;
            end
          end
        end
        D_STEP: begin
          pst_q   <= pst_step_d;
          drive_q <= hold_vec(pst_step_d);
          idx_q   <= idx_q + 2'd1;
          drv_q   <= D_CHECK;
        end
        // A failed check aborts the rest of the path; pst always follows the observed code
        D_CHECK: begin
          pst_q <= obs_st_d;
          if (check_ok && (idx_q < rom_steps)) begin
            drv_q   <= D_STEP;
            drive_q <= step_vec_d;
          end else begin
            drv_q        <= D_RESP;
            drive_q      <= hold_vec(obs_st_d);
            resp_valid_q <= 1'b1;
            resp_steps_q <= idx_q;
            if (!check_ok) begin
              resp_err_q <= 1'b1;
              if (mis_q != {CNT_W{1'b1}}) mis_q <= mis_q + 1'b1;
            end
          end
        end
        D_RESP: begin
          resp_valid_q <= 1'b0;
          drive_q      <= hold_vec(pst_q);
          drv_q        <= D_IDLE;
        end
        default: drv_q <= D_IDLE;
      endcase
    end
  end

  assign req_ready  = (drv_q == D_IDLE);
  assign i1         = drive_q[1];
  assign i2         = drive_q[0];
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_steps = resp_steps_q;
  assign mis_cnt    = mis_q;

endmodule

// File: tb/tb_sm_para_2_driver.sv
// Bench for sm_para_2_driver: a behavioural target FSM plus a cycle-level
// expectation of the drive schedule, responses and mismatch count.
module tb_sm_para_2_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_state;
  logic       i1, i2;
  logic       o1, o2, err;
  logic       resp_valid, resp_err;
  logic [1:0] resp_steps;
  logic [7:0] mis_cnt;

  int testsRun = 0;
  int failCount = 0;

  // Target FSM environment: 0 IDLE, 1 S1, 2 S2, 3 ERROR
  int  tState;
  bit  tgtRst;
  bit  forceReq;
  int  forceVal;

  // Model state: predicted-state view, actual target state, mismatch count
  int mPst, mAct, mMis;

  int         pathN[4][4];
  logic [1:0] pathV[4][4][3];

  always #5 clk = ~clk;

  sm_para_2_driver #(.CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_state  (req_state),
    .i1         (i1),
    .i2         (i2),
    .o1         (o1),
    .o2         (o2),
    .err        (err),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_steps (resp_steps),
    .mis_cnt    (mis_cnt)
  );

  function automatic int tbNext(input int s, input logic [1:0] v);
    case (s)
      0:       return !v[1] ? 0 : (v[0] ? 1 : 3);
      1:       return !v[0] ? 1 : (v[1] ? 2 : 3);
      2:       return v[0] ? 2 : (v[1] ? 0 : 3);
      default: return v[1] ? 3 : 0;
    endcase
  endfunction

  function automatic logic [1:0] tbHold(input int s);
    case (s)
      2:       return 2'b01;
      3:       return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] tbCode(input int s);
    case (s)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (tgtRst)        tState <= 0;
    else if (forceReq) tState <= forceVal;
    else               tState <= tbNext(tState, {i1, i2});
  end

  assign {o1, o2, err} = tbCode(tState);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic setPath(input int f, input int t, input int n,
                         input logic [1:0] v0, input logic [1:0] v1, input logic [1:0] v2);
    pathN[f][t] = n;
    pathV[f][t][0] = v0;
    pathV[f][t][1] = v1;
    pathV[f][t][2] = v2;
  endtask

  task automatic checkBusy(input string tag, input logic [1:0] vec);
    checkOutput(tag, 32'({i1, i2}), 32'(vec));
    checkOutput("busy_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("busy_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic nextCycle(input bit keepValid);
    @(negedge clk);
    if (keepValid) req_state = 2'($urandom_range(0, 3));
  endtask

  task automatic idleCycle();
    checkOutput("idle_ready", 32'(req_ready), 32'd1);
    checkOutput("idle_hold", 32'({i1, i2}), 32'(tbHold(mPst)));
    mAct = tbNext(mAct, tbHold(mPst));
    @(negedge clk);
  endtask

  // Called in a ready cycle; issues one request and follows it to the next ready cycle
  task automatic applyStimulus(input int target, input int forceTo, input bit keepValid);
    int   from, n, act, pred, obs, done;
    bit   bad;
    logic [1:0] v;
    from = mPst;
    n    = pathN[from][target];
    act  = mAct;
    pred = from;
    obs  = from;
    done = 0;
    bad  = 1'b0;
    checkOutput("accept_ready", 32'(req_ready), 32'd1);
    checkOutput("accept_hold", 32'({i1, i2}), 32'(tbHold(from)));
    req_valid = 1'b1;
    req_state = 2'(target);
    if (forceTo >= 0) begin
      forceReq = 1'b1;
      forceVal = forceTo;
      act      = forceTo;
    end else begin
      act = tbNext(act, tbHold(from));
    end
    @(negedge clk);
    forceReq  = 1'b0;
    req_valid = keepValid;
    if (keepValid) req_state = 2'($urandom_range(0, 3));
    if (n == 0) begin
      checkBusy("check_drive", tbHold(pred));
      bad = (act != pred);
      obs = act;
      act = tbNext(act, tbHold(pred));
      nextCycle(keepValid);
    end else begin
      for (int s = 0; s < n && !bad; s++) begin
        v = pathV[from][target][s];
        checkBusy("step_drive", v);
        act  = tbNext(act, v);
        pred = tbNext(pred, v);
        done = s + 1;
        nextCycle(keepValid);
        checkBusy("check_drive", tbHold(pred));
        bad = (act != pred);
        obs = act;
        act = tbNext(act, tbHold(pred));
        nextCycle(keepValid);
      end
    end
    checkOutput("resp_valid", 32'(resp_valid), 32'd1);
    checkOutput("resp_err", 32'(resp_err), 32'(bad));
    checkOutput("resp_steps", 32'(resp_steps), 32'(done));
    checkOutput("resp_ready", 32'(req_ready), 32'd0);
    checkOutput("resp_hold", 32'({i1, i2}), 32'(tbHold(obs)));
    act = tbNext(act, tbHold(obs));
    @(negedge clk);
    req_valid = 1'b0;
    if (bad && mMis < 255) mMis++;
    checkOutput("after_ready", 32'(req_ready), 32'd1);
    checkOutput("after_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("mis_cnt", 32'(mis_cnt), 32'(mMis));
    checkOutput("after_hold", 32'({i1, i2}), 32'(tbHold(obs)));
    checkOutput("target_code", 32'({o1, o2, err}), 32'(tbCode(act)));
    mPst = obs;
    mAct = act;
  endtask

  // Starts a 3-step ERROR->S2 request and resets the driver in its third cycle
  task automatic resetMidOp();
    int pred;
    checkOutput("rmo_start_pst", 32'(mPst), 32'd3);
    req_valid = 1'b1;
    req_state = 2'd2;
    mAct = tbNext(mAct, tbHold(mPst));
    @(negedge clk);
    req_valid = 1'b0;
    checkBusy("rmo_step0", pathV[3][2][0]);
    mAct = tbNext(mAct, pathV[3][2][0]);
    pred = tbNext(mPst, pathV[3][2][0]);
    @(negedge clk);
    checkBusy("rmo_check0", tbHold(pred));
    mAct = tbNext(mAct, tbHold(pred));
    @(negedge clk);
    checkBusy("rmo_step1", pathV[3][2][1]);
    rst  = 1'b1;
    mAct = tbNext(mAct, pathV[3][2][1]);
    @(negedge clk);
    rst  = 1'b0;
    mPst = 0;
    mMis = 0;
    checkOutput("rmo_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rmo_drive", 32'({i1, i2}), 32'd0);
    checkOutput("rmo_ready", 32'(req_ready), 32'd1);
    checkOutput("rmo_mis_cnt", 32'(mis_cnt), 32'd0);
    checkOutput("rmo_resp_steps", 32'(resp_steps), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, failed=%0d", failCount);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int f = 0; f < 4; f++)
      for (int t = 0; t < 4; t++)
        setPath(f, t, 0, 2'b00, 2'b00, 2'b00);
    setPath(1, 0, 2, 2'b11, 2'b10, 2'b00);
    setPath(2, 0, 1, 2'b10, 2'b00, 2'b00);
    setPath(3, 0, 1, 2'b00, 2'b00, 2'b00);
    setPath(0, 1, 1, 2'b11, 2'b00, 2'b00);
    setPath(2, 1, 2, 2'b10, 2'b11, 2'b00);
    setPath(3, 1, 2, 2'b00, 2'b11, 2'b00);
    setPath(0, 2, 2, 2'b11, 2'b11, 2'b00);
    setPath(1, 2, 1, 2'b11, 2'b00, 2'b00);
    setPath(3, 2, 3, 2'b00, 2'b11, 2'b11);
    setPath(0, 3, 1, 2'b10, 2'b00, 2'b00);
    setPath(1, 3, 1, 2'b01, 2'b00, 2'b00);
    setPath(2, 3, 1, 2'b00, 2'b00, 2'b00);

    rst       = 1'b1;
    tgtRst    = 1'b1;
    forceReq  = 1'b0;
    forceVal  = 0;
    req_valid = 1'b0;
    req_state = 2'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_drive", 32'({i1, i2}), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_steps", 32'(resp_steps), 32'd0);
    checkOutput("rst_mis_cnt", 32'(mis_cnt), 32'd0);
    rst    = 1'b0;
    tgtRst = 1'b0;
    mPst   = 0;
    mAct   = 0;
    mMis   = 0;

    applyStimulus(2, -1, 1'b0);
    applyStimulus(3, -1, 1'b0);
    applyStimulus(0, -1, 1'b0);
    applyStimulus(3, -1, 1'b0);
    applyStimulus(2, -1, 1'b0);
    applyStimulus(0, -1, 1'b0);
    applyStimulus(1, 3, 1'b0);
    checkOutput("resync_pst", 32'(mPst), 32'd3);
    applyStimulus(1, -1, 1'b0);
    applyStimulus(1, -1, 1'b0);
    idleCycle();
    applyStimulus(2, -1, 1'b1);
    applyStimulus(0, -1, 1'b0);
    applyStimulus(3, -1, 1'b0);
    resetMidOp();

    for (int it = 0; it < 60; it++) begin
      int tgt, frc;
      bit keep;
      if ($urandom_range(0, 4) == 0) idleCycle();
      tgt  = $urandom_range(0, 3);
      frc  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      keep = ($urandom_range(0, 3) == 0);
      applyStimulus(tgt, frc, keep);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
